boton_ar_multi: RTL and testbench

- Parametrised N-channel push-button conditioner; successor to the single-channel Boton_AR debouncer.
- Per channel it provides: a 2-FF synchroniser, a debounce counter FSM, and a debounced level output.
- It also emits one-cycle press and release pulses, a long-press pulse and a per-channel toggle output.
- Sits between board pins and the game/control FSMs; replaces the per-button Boton_AR instances and the ad-hoc LED toggle logic.

---
 rtl/boton_ar_multi_if.sv | 30 +++
 rtl/boton_ar_multi.sv | 160 ++++++++++++++++
 tb/tb_boton_ar_multi.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/boton_ar_multi_if.sv
// Button-conditioner bus: raw pins in, conditioned levels and strobes out.
// The board side drives boton_in; the conditioner drives everything else.
interface boton_ar_multi_if #(
    parameter int N_CANALES = 3
);
    logic [N_CANALES-1:0] boton_in;
    logic [N_CANALES-1:0] estado;
    logic [N_CANALES-1:0] pulso_on;
    logic [N_CANALES-1:0] pulso_off;
    logic [N_CANALES-1:0] pulso_largo;
    logic [N_CANALES-1:0] toggle;

    modport master (
        output boton_in,
        input  estado,
        input  pulso_on,
        input  pulso_off,
        input  pulso_largo,
        input  toggle
    );

    modport slave (
        input  boton_in,
        output estado,
        output pulso_on,
        output pulso_off,
        output pulso_largo,
        output toggle
    );
endinterface

// File: rtl/boton_ar_multi.sv
// N-channel push-button conditioner: sync, debounce, edge/long-press strobes.
// Every output is a flop; channels share nothing but the clock and reset.
module boton_ar_multi #(
    parameter int N_CANALES       = 3,
    parameter int DEBOUNCE_CYCLES = 1500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic              clk,
    input  logic              reset,
    boton_ar_multi_if.slave   bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int HW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
    localparam bit LONG_EN = (LONG_CYCLES > 0);

    typedef enum logic [1:0] {
        SUELTO,
        FILTRO_ON,
        PRESIONADO,
        FILTRO_OFF
    } estado_t;

    logic [N_CANALES-1:0] x;
    logic [N_CANALES-1:0] s1;
    logic [N_CANALES-1:0] s2;

    logic [N_CANALES-1:0] est_v;
    logic [N_CANALES-1:0] on_v;
    logic [N_CANALES-1:0] off_v;
    logic [N_CANALES-1:0] lg_v;
    logic [N_CANALES-1:0] tog_v;

    // Polarity is normalised before the synchroniser so s2 always means "pressed".
    assign x = (ACTIVE_LOW != 0) ? ~bus.boton_in : bus.boton_in;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= x;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
        estado_t       st;
        estado_t       st_n;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_n;
        logic [HW-1:0] hcnt;
        logic [HW-1:0] hcnt_n;
        logic          est_n;
        logic          on_n;
        logic          off_n;
        logic          lg_n;
        logic          tog_n;
        logic          est_q;
        logic          on_q;
        logic          off_q;
        logic          lg_q;
        logic          tog_q;

        // Next state, counters and strobes; the hold counter runs in both pressed states.
        always_comb begin
            st_n   = st;
            cnt_n  = cnt;
            hcnt_n = hcnt;
            on_n   = 1'b0;
            off_n  = 1'b0;
            lg_n   = 1'b0;
            tog_n  = tog_q;

            if (LONG_EN && (st == PRESIONADO || st == FILTRO_OFF)
                && (hcnt < HOLD_MAX)) begin
                hcnt_n = hcnt + 1'b1;
                lg_n   = (hcnt_n == HOLD_MAX);
            end

            unique case (st)
                SUELTO: begin
                    if (s2[i]) begin
                        st_n  = FILTRO_ON;
                        cnt_n = '0;
                    end
                end
                FILTRO_ON: begin
                    if (!s2[i]) begin
                        st_n = SUELTO;
                    end else if (cnt == CNT_LAST) begin
                        st_n   = PRESIONADO;
                        on_n   = 1'b1;
                        tog_n  = ~tog_q;
                        hcnt_n = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                PRESIONADO: begin
                    if (!s2[i]) begin
                        st_n  = FILTRO_OFF;
                        cnt_n = '0;
                    end
                end
                FILTRO_OFF: begin
                    if (s2[i]) begin
                        st_n = PRESIONADO;
                    end else if (cnt == CNT_LAST) begin
                        st_n  = SUELTO;
                        off_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: st_n = SUELTO;
            endcase

            est_n = (st_n == PRESIONADO) || (st_n == FILTRO_OFF);
        end

        // State, counters and output flops for this channel.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st    <= SUELTO;
                cnt   <= '0;
                hcnt  <= '0;
                est_q <= 1'b0;
                on_q  <= 1'b0;
                off_q <= 1'b0;
                lg_q  <= 1'b0;
                tog_q <= 1'b0;
            end else begin
                st    <= st_n;
                cnt   <= cnt_n;
                hcnt  <= hcnt_n;
                est_q <= est_n;
                on_q  <= on_n;
                off_q <= off_n;
                lg_q  <= lg_n;
                tog_q <= tog_n;
            end
        end

        assign est_v[i] = est_q;
        assign on_v[i]  = on_q;
        assign off_v[i] = off_q;
        assign lg_v[i]  = lg_q;
        assign tog_v[i] = tog_q;
    end

    assign bus.estado      = est_v;
    assign bus.pulso_on    = on_v;
    assign bus.pulso_off   = off_v;
    assign bus.pulso_largo = lg_v;
    assign bus.toggle      = tog_v;
endmodule

// File: tb/tb_boton_ar_multi.sv
// Bench for boton_ar_multi: active-high and active-low instances against
// a run-length reference model, plus hand-timed scenario checks.
module tb_boton_ar_multi;
    localparam int N = 3;
    localparam int D = 4;
    localparam int L = 10;

    logic clk;
    logic reset;

    int total;
    int passed;
    int cyc;

    boton_ar_multi_if #(.N_CANALES(N)) bus_hi ();
    boton_ar_multi_if #(.N_CANALES(N)) bus_lo ();

    boton_ar_multi #(
        .N_CANALES(N), .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L), .ACTIVE_LOW(0)
    ) dut_hi (
        .clk(clk), .reset(reset), .bus(bus_hi.slave)
    );

    boton_ar_multi #(
        .N_CANALES(N), .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L), .ACTIVE_LOW(1)
    ) dut_lo (
        .clk(clk), .reset(reset), .bus(bus_lo.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act,
                         input logic [N-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    // Reference model: the pipeline delay is two samples; a level flips once
    // the synchronised input has disagreed with it for D+1 consecutive edges.
    int p1 [2][N];
    int p2 [2][N];
    int lvl [2][N];
    int run [2][N];
    int age [2][N];
    int tog [2][N];
    logic [N-1:0] e_est [2];
    logic [N-1:0] e_on [2];
    logic [N-1:0] e_off [2];
    logic [N-1:0] e_lg [2];
    logic [N-1:0] e_tog [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < N; c++) begin
                    p1[m][c] = 0; p2[m][c] = 0; lvl[m][c] = 0;
                    run[m][c] = 0; age[m][c] = 0; tog[m][c] = 0;
                end
                e_est[m] = '0; e_on[m] = '0; e_off[m] = '0;
                e_lg[m] = '0; e_tog[m] = '0;
            end
        end else begin
            cyc++;
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < N; c++) begin
                    int xin, s, prior;
                    xin = (m == 0) ? int'(bus_hi.boton_in[c])
                                   : int'(!bus_lo.boton_in[c]);
                    s = p2[m][c];
                    p2[m][c] = p1[m][c];
                    p1[m][c] = xin;
                    prior = lvl[m][c];
                    e_on[m][c] = 1'b0;
                    e_off[m][c] = 1'b0;
                    e_lg[m][c] = 1'b0;
                    if (s != lvl[m][c]) run[m][c]++;
                    else run[m][c] = 0;
                    if (run[m][c] == D + 1) begin
                        lvl[m][c] = 1 - lvl[m][c];
                        run[m][c] = 0;
                        if (lvl[m][c] == 1) begin
                            e_on[m][c] = 1'b1;
                            tog[m][c] = 1 - tog[m][c];
                            age[m][c] = 0;
                        end else begin
                            e_off[m][c] = 1'b1;
                        end
                    end
                    if (prior == 1) begin
                        age[m][c]++;
                        if (L > 0 && age[m][c] == L) e_lg[m][c] = 1'b1;
                    end
                    e_est[m][c] = (lvl[m][c] == 1);
                    e_tog[m][c] = (tog[m][c] == 1);
                end
            end
        end
    end

    int on_cnt [N];
    int off_cnt [N];
    int lg_cnt [N];

    // Every-cycle comparison against the model, plus event tallies.
    always @(negedge clk) begin
        check("hi_estado", bus_hi.estado, e_est[0]);
        check("hi_on", bus_hi.pulso_on, e_on[0]);
        check("hi_off", bus_hi.pulso_off, e_off[0]);
        check("hi_largo", bus_hi.pulso_largo, e_lg[0]);
        check("hi_toggle", bus_hi.toggle, e_tog[0]);
        check("lo_estado", bus_lo.estado, e_est[1]);
        check("lo_on", bus_lo.pulso_on, e_on[1]);
        check("lo_off", bus_lo.pulso_off, e_off[1]);
        check("lo_largo", bus_lo.pulso_largo, e_lg[1]);
        check("lo_toggle", bus_lo.toggle, e_tog[1]);
        check("hi_on_off_excl", bus_hi.pulso_on & bus_hi.pulso_off, '0);
        for (int c = 0; c < N; c++) begin
            on_cnt[c] += int'(bus_hi.pulso_on[c]);
            off_cnt[c] += int'(bus_hi.pulso_off[c]);
            lg_cnt[c] += int'(bus_hi.pulso_largo[c]);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_estado"}, bus_hi.estado, '0);
        check({tag, "_on"}, bus_hi.pulso_on, '0);
        check({tag, "_off"}, bus_hi.pulso_off, '0);
        check({tag, "_largo"}, bus_hi.pulso_largo, '0);
        check({tag, "_toggle"}, bus_hi.toggle, '0);
        check({tag, "_lo_estado"}, bus_lo.estado, '0);
        check({tag, "_lo_toggle"}, bus_lo.toggle, '0);
    endtask

    initial begin
        total = 0;
        passed = 0;
        cyc = 0;
        for (int c = 0; c < N; c++) begin
            on_cnt[c] = 0; off_cnt[c] = 0; lg_cnt[c] = 0;
        end
        reset = 1'b1;
        bus_hi.boton_in = '0;
        bus_lo.boton_in = '1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 1: clean press on channel 0, long pulse, release.
        bus_hi.boton_in[0] = 1'b1;
        edges(6);
        check("t1_on_early", {2'b0, bus_hi.pulso_on[0]}, 3'd0);
        edges(1);
        check("t1_on", {2'b0, bus_hi.pulso_on[0]}, 3'd1);
        check("t1_estado", {2'b0, bus_hi.estado[0]}, 3'd1);
        check("t1_toggle", {2'b0, bus_hi.toggle[0]}, 3'd1);
        edges(1);
        check("t1_on_once", {2'b0, bus_hi.pulso_on[0]}, 3'd0);
        edges(8);
        check("t1_lg_early", {2'b0, bus_hi.pulso_largo[0]}, 3'd0);
        edges(1);
        check("t1_lg", {2'b0, bus_hi.pulso_largo[0]}, 3'd1);
        edges(1);
        check("t1_lg_once", {2'b0, bus_hi.pulso_largo[0]}, 3'd0);
        repeat (13) @(negedge clk);
        bus_hi.boton_in[0] = 1'b0;
        edges(6);
        check("t1_off_early", {2'b0, bus_hi.pulso_off[0]}, 3'd0);
        edges(1);
        check("t1_off", {2'b0, bus_hi.pulso_off[0]}, 3'd1);
        check("t1_estado_rel", {2'b0, bus_hi.estado[0]}, 3'd0);
        repeat (4) @(negedge clk);

        // 2: bounce on channel 1 never settles long enough.
        bus_hi.boton_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        bus_hi.boton_in[1] = 1'b0;
        @(negedge clk);
        bus_hi.boton_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        bus_hi.boton_in[1] = 1'b0;
        repeat (12) @(negedge clk);
        check("t2_on_cnt", 3'(on_cnt[1]), 3'd0);
        check("t2_off_cnt", 3'(off_cnt[1]), 3'd0);
        check("t2_estado", {2'b0, bus_hi.estado[1]}, 3'd0);
        check("t2_toggle", {2'b0, bus_hi.toggle[1]}, 3'd0);

        // 3: short press on channel 2.
        bus_hi.boton_in[2] = 1'b1;
        repeat (8) @(negedge clk);
        bus_hi.boton_in[2] = 1'b0;
        repeat (20) @(negedge clk);
        check("t3_on_cnt", 3'(on_cnt[2]), 3'd1);
        check("t3_off_cnt", 3'(off_cnt[2]), 3'd1);
        check("t3_lg_cnt", 3'(lg_cnt[2]), 3'd0);
        check("t3_toggle", {2'b0, bus_hi.toggle[2]}, 3'd1);

        // 4: all channels together.
        bus_hi.boton_in = '1;
        edges(7);
        check("t4_on_all", bus_hi.pulso_on, 3'b111);
        check("t4_toggle", bus_hi.toggle, 3'b010);
        @(negedge clk);
        bus_hi.boton_in = '0;
        repeat (12) @(negedge clk);

        // 5: reset while pressed, button still held afterwards.
        bus_hi.boton_in[0] = 1'b1;
        edges(7);
        check("t5_pressed", {2'b0, bus_hi.estado[0]}, 3'd1);
        #2 reset = 1'b1;
        #1 check_all_zero("t5_async");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        edges(6);
        check("t5_on_early", {2'b0, bus_hi.pulso_on[0]}, 3'd0);
        edges(1);
        check("t5_on", {2'b0, bus_hi.pulso_on[0]}, 3'd1);
        @(negedge clk);
        bus_hi.boton_in[0] = 1'b0;
        repeat (12) @(negedge clk);

        // 6: active-low instance.
        bus_lo.boton_in[0] = 1'b0;
        edges(6);
        check("t6_on_early", {2'b0, bus_lo.pulso_on[0]}, 3'd0);
        edges(1);
        check("t6_on", {2'b0, bus_lo.pulso_on[0]}, 3'd1);
        check("t6_estado", {2'b0, bus_lo.estado[0]}, 3'd1);
        @(negedge clk);
        bus_lo.boton_in[0] = 1'b1;
        repeat (12) @(negedge clk);

        // Random bouncing and holding on every channel of both instances.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 7) == 0)
                    bus_hi.boton_in[c] = ~bus_hi.boton_in[c];
                if ($urandom_range(0, 7) == 0)
                    bus_lo.boton_in[c] = ~bus_lo.boton_in[c];
            end
        end
        @(negedge clk);
        bus_hi.boton_in = '0;
        bus_lo.boton_in = '1;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
